store_write_buffer: RTL and testbench
=====================================

Name: store_write_buffer

Overview:
- FIFO store buffer between the pipelined core's memory stage and the data-memory/cache system.
- Accepts word stores from the core in a single cycle and drains them to memory under a valid/ready handshake, so memory latency does not stall the pipeline.
- Forwards buffered store data to loads from the same stage.
- Supports a flush (fence) request that blocks new stores until the buffer is empty.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous active-low reset.
- st_valid  in  1  store request; driven from MemWriteM.
- st_addr  in  AW  store word address.
- st_data  in  DW  store data.
- st_ready  out  1  store accepted this cycle if st_valid is high.
- ld_valid  in  1  load lookup request.
- ld_addr  in  AW  load word address.
- ld_hit  out  1  a buffered store matches ld_addr (combinational).
- ld_data  out  DW  data of the youngest matching entry; 0 when no hit.
- mem_we  out  1  head entry valid toward memory.
- mem_addr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_ready  in  1  memory accepts the head entry at this edge.
- flush_req  in  1  level request to drain the buffer completely.
- flush_done  out  1  one-cycle pulse when a flush completes.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- Storage: DEPTH entries of {addr, data}, circular. head_ptr and tail_ptr are log2(DEPTH) bits and wrap modulo DEPTH. count is held separately.
- Reset (low, asynchronous):
  - pointers, count and FSM state go to 0/RUN; entries are invalidated.
  - mem_we=0, mem_addr=0, mem_wdata=0, flush_done=0, st_ready=0 while asserted, empty=1, full=0.
  - Reset mid-drain discards all pending stores without handshake.
- Enqueue: st_valid && st_ready at a rising edge writes the entry at tail_ptr, then tail_ptr+1 and count+1.
- st_ready = !full && state==RUN. When st_ready=0 the core must hold the request; it is not accepted.
- Dequeue:
  - mem_we = !empty; mem_addr/mem_wdata = head entry, 0 when empty.
  - mem_we && mem_ready at an edge advances head_ptr and decrements count.
  - mem_ready while empty is ignored.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. This is legal at any occupancy except full: full blocks the enqueue, so there is no same-cycle pass-through.
- Forwarding:
  - ld_hit = ld_valid && some occupied entry has addr == ld_addr (full AW compare).
  - ld_data = youngest matching entry, searched from tail-1 back to head.
  - A store being enqueued in the same cycle is not visible to forwarding.
  - The head entry being drained in that cycle is still visible.
- FSM:
  - RUN: normal operation. On flush_req go to FLUSH, or to DONE if already empty.
  - FLUSH: st_ready=0, draining continues. When count reaches 0 (after the final dequeue edge), go to DONE.
  - DONE: flush_done=1 for exactly one cycle, st_ready=0. Then go to RUN, regardless of flush_req.
  - The requester must drop flush_req on seeing flush_done. If flush_req is still high in RUN, a new flush starts (it completes immediately when empty).
- count never exceeds DEPTH and never underflows.

Optional Feature:
- Macro: SWB_COALESCE_EN.
- Enabled: a store whose st_addr equals the newest entry's addr overwrites that entry's data in place. count and tail_ptr are unchanged.
  - Coalescing applies only when count >= 2, so the head presented to memory is never modified.
  - st_ready is high for coalescing stores even when full (still 0 in FLUSH/DONE).
- Disabled: every accepted store allocates a new entry.

Test Plan:
- Reset, then 4 stores (A=0x100..0x10C, D=0x11..0x44) with mem_ready=0 -> full=1, count=4, st_ready=0, mem_we=1, mem_addr=0x100, mem_wdata=0x11. A fifth store is held, not accepted.
- mem_ready=1 continuously -> writes appear on consecutive cycles in order 0x100, 0x104, 0x108, 0x10C. empty=1 after the 4th edge. Pointers wrap correctly over 3 more fill/drain rounds.
- Store 0x200=0xAA then 0x200=0xBB (coalescing off), load 0x200 -> ld_hit=1, ld_data=0xBB, count=2. Load 0x300 -> ld_hit=0, ld_data=0.
- Occupancy 2: simultaneous store and mem_ready -> count stays 2, both pointers advance, data order preserved.
- 3 entries, flush_req=1, mem_ready every other cycle:
  - st_ready=0 throughout.
  - flush_done pulses exactly once, in the cycle after count reaches 0.
  - st_ready returns to 1 the following cycle.
- reset driven low while count=3 and mem_we=1 -> mem_we drops asynchronously, count=0. After release, the first accepted store appears at mem_addr.
- With SWB_COALESCE_EN: full buffer with newest addr 0x10C; store 0x10C=0x99 -> accepted, count=4, and the 4th drain shows 0x99.

Source files
------------

// File: rtl/store_write_buffer.sv
// -----------------------------------------------------------------------------
// store_write_buffer
//   FIFO store buffer between the core's memory stage and data memory. Stores
//   are accepted in one cycle and drained under a valid/ready handshake. Loads
//   from the same stage are forwarded the youngest buffered store data. A flush
//   request blocks new stores until the buffer has drained completely.
//
// Parameters
//   DEPTH  number of entries (power of two, >= 2)
//   AW     address width
//   DW     data width
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   st_valid/addr/data    store request from the core
//   st_ready              store accepted this cycle when st_valid is high
//   ld_valid/addr         load lookup
//   ld_hit/ld_data        forwarding result (combinational), data 0 on miss
//   mem_we/addr/wdata     head entry toward memory
//   mem_ready             memory takes the head entry at this edge
//   flush_req/flush_done  drain request (level) / completion pulse
//   count, empty, full    occupancy
//
// Optional feature
//   SWB_COALESCE_EN  when defined, a store to the newest entry's address
//                    overwrites that entry's data in place (only with two or
//                    more entries, so the head seen by memory never changes).
//
// FSM states
//   state | meaning
//   RUN   | normal operation, stores accepted when not full
//   FLUSH | stores blocked, buffer draining
//   DONE  | buffer empty, flush_done pulsed for one cycle
// -----------------------------------------------------------------------------
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hit,
    output logic [DW-1:0]              ld_data,
    output logic                       mem_we,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic                       mem_ready,
    input  logic                       flush_req,
    output logic                       flush_done,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   addr_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [PW-1:0]   head_ptr, tail_ptr;
    logic [CW-1:0]   count_q;
    logic            coal_hit;
    logic            enq;
    logic            coal_wr;
    logic            deq;

`ifdef SWB_COALESCE_EN
    logic [PW-1:0]   newest_ptr;
    assign newest_ptr = tail_ptr - PW'(1);
`endif

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Store acceptance. st_ready is gated by reset so it reads 0 while the
    // buffer is held in reset.
    always_comb begin
        coal_hit = 1'b0;
`ifdef SWB_COALESCE_EN
        coal_hit = (count_q >= CW'(2)) && (addr_q[newest_ptr] == st_addr);
`endif
        st_ready = reset && (state == RUN) && (!full || coal_hit);
        enq      = st_valid && st_ready && !coal_hit;
        coal_wr  = st_valid && st_ready && coal_hit;
    end

    // Memory side: head entry, zeroed when empty.
    always_comb begin
        mem_we    = !empty;
        mem_addr  = empty ? '0 : addr_q[head_ptr];
        mem_wdata = empty ? '0 : data_q[head_ptr];
        deq       = mem_we && mem_ready;
    end

    // Forwarding: walk oldest to youngest so the youngest match wins. Only
    // registered entries are searched, so a same-cycle store is invisible and
    // the head being drained is still visible.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_valid && (CW'(i) < count_q) &&
                (addr_q[head_ptr + PW'(i)] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[head_ptr + PW'(i)];
            end
        end
    end

    // Next state. From RUN an empty buffer finishes at once, unless a store
    // lands on the same edge, in which case it must drain first.
    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            RUN: begin
                if (flush_req) begin
                    state_nxt = (empty && !enq) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                if (empty) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                state_nxt  = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            head_ptr <= '0;
            tail_ptr <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (enq) begin
                addr_q[tail_ptr] <= st_addr;
                data_q[tail_ptr] <= st_data;
                tail_ptr         <= tail_ptr + PW'(1);
            end
`ifdef SWB_COALESCE_EN
            if (coal_wr) begin
                data_q[newest_ptr] <= st_data;
            end
`endif
            if (deq) begin
                head_ptr <= head_ptr + PW'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          st_valid = 1'b0;
    logic [31:0]   st_addr = '0;
    logic [31:0]   st_data = '0;
    logic          st_ready;
    logic          ld_valid = 1'b0;
    logic [31:0]   ld_addr = '0;
    logic          ld_hit;
    logic [31:0]   ld_data;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ready = 1'b0;
    logic          flush_req = 1'b0;
    logic          flush_done;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;

    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t mq[$];     // reference buffer contents, oldest first
    ent_t sb_q[$];   // scoreboard of expected memory writes
    bit   blocked  = 1'b0;  // stores expected to be refused (flush in progress)
    bit   exp_done = 1'b0;
    int   last_size;

    store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .st_valid   (st_valid),
        .st_addr    (st_addr),
        .st_data    (st_data),
        .st_ready   (st_ready),
        .ld_valid   (ld_valid),
        .ld_addr    (ld_addr),
        .ld_hit     (ld_hit),
        .ld_data    (ld_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every handshake with memory must match the oldest expected write.
    always @(negedge clk) begin
        if (reset && mem_we && mem_ready) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL drain_unexpected: got write %0h expected none", mem_addr);
            end else begin
                ent_t e;
                e = sb_q.pop_front();
                chk("drain_addr", 64'(mem_addr), 64'(e.a));
                chk("drain_data", 64'(mem_wdata), 64'(e.d));
            end
        end
    end

    // One clock of stimulus: drive after the edge, check at the falling edge
    // against the reference model, then advance the model across the next edge.
    task automatic step(input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                        input bit lv, input logic [31:0] la, input bit mr, input bit fr);
        bit          rdy, coal, hit;
        logic [31:0] hd, ha, hdat;
        int          n;
        @(posedge clk);
        #1;
        st_valid = sv; st_addr = sa; st_data = sd;
        ld_valid = lv; ld_addr = la; mem_ready = mr; flush_req = fr;
        @(negedge clk);
        n = mq.size();
        last_size = n;
        coal = 1'b0;
`ifdef SWB_COALESCE_EN
        if (n >= 2) coal = (sa == mq[n-1].a);
`endif
        rdy = !blocked && ((n < DEPTH) || coal);
        hit = 1'b0;
        hd  = '0;
        if (lv) begin
            foreach (mq[i]) begin
                if (mq[i].a == la) begin
                    hit = 1'b1;
                    hd  = mq[i].d;
                end
            end
        end
        ha   = '0;
        hdat = '0;
        if (n != 0) begin
            ha   = mq[0].a;
            hdat = mq[0].d;
        end
        chk("count", 64'(count), 64'(n));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("full", 64'(full), 64'(n == DEPTH));
        chk("st_ready", 64'(st_ready), 64'(rdy));
        chk("flush_done", 64'(flush_done), 64'(exp_done));
        chk("mem_we", 64'(mem_we), 64'(n != 0));
        chk("mem_addr", 64'(mem_addr), 64'(ha));
        chk("mem_wdata", 64'(mem_wdata), 64'(hdat));
        chk("ld_hit", 64'(ld_hit), 64'(hit));
        chk("ld_data", 64'(ld_data), 64'(hd));
        if (n != 0 && mr) void'(mq.pop_front());
        if (sv && rdy) begin
            if (coal) begin
                mq[$].d   = sd;
                sb_q[$].d = sd;
            end else begin
                mq.push_back('{a: sa, d: sd});
                sb_q.push_back('{a: sa, d: sd});
            end
        end
    endtask

    task automatic idle(input bit mr);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, mr, 1'b0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit mr);
        step(1'b1, a, d, 1'b0, 32'h0, mr, 1'b0);
    endtask

    task automatic load(input logic [31:0] a);
        step(1'b0, 32'h0, 32'h0, 1'b1, a, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // reset state, checked while reset is still asserted
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_st_ready", 64'(st_ready), 64'd0);
        chk("rst_flush_done", 64'(flush_done), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // fill to full with memory stalled, then a fifth store must be held
        for (int i = 0; i < 4; i++) store(32'h100 + 32'(4*i), 32'h11 * 32'(i+1), 1'b0);
        store(32'h110, 32'h55, 1'b0);
        idle(1'b0);
        // drain back to back, then three more wrap rounds
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) store(32'h1000 * 32'(r+1) + 32'(4*i), $urandom, 1'b0);
            for (int i = 0; i < 4; i++) idle(1'b1);
        end
        idle(1'b0);

        // youngest-match forwarding and miss
        store(32'h200, 32'hAA, 1'b0);
        store(32'h200, 32'hBB, 1'b0);
        load(32'h200);
        load(32'h300);
        // enqueue and dequeue on the same edge at occupancy 2
        store(32'h204, 32'hCC, 1'b1);
        idle(1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // flush with three entries and memory ready every other cycle
        for (int i = 0; i < 3; i++) store(32'h600 + 32'(4*i), 32'h60 + 32'(i), 1'b0);
        blocked = 1'b0;
        exp_done = 1'b0;
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        blocked = 1'b1;
        begin
            bit prev0 = 1'b0;
            bit seen  = 1'b0;
            for (int n = 0; n < 40 && !seen; n++) begin
                exp_done = prev0;
                step(1'b1, 32'h700, 32'h77, 1'b0, 32'h0, (n % 2) == 0, 1'b1);
                seen  = exp_done;
                prev0 = (last_size == 0);
            end
            if (!seen) begin
                n_chk++;
                n_fail++;
                $display("FAIL flush_timeout: got no flush_done expected one within 40 cycles");
            end
        end
        blocked = 1'b0;
        exp_done = 1'b0;
        idle(1'b0);

        // flush on an empty buffer completes on the next cycle
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        blocked = 1'b1;
        exp_done = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        blocked = 1'b0;
        exp_done = 1'b0;
        idle(1'b0);

`ifdef SWB_COALESCE_EN
        for (int i = 0; i < 4; i++) store(32'h100 + 32'(4*i), 32'h11 * 32'(i+1), 1'b0);
        store(32'h10C, 32'h99, 1'b0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);
`endif

        // asynchronous reset in the middle of a pending drain
        for (int i = 0; i < 3; i++) store(32'h800 + 32'(4*i), 32'h80 + 32'(i), 1'b0);
        idle(1'b0);
        #2;
        st_valid = 1'b0; ld_valid = 1'b0; mem_ready = 1'b1; flush_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("arst_mem_we", 64'(mem_we), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_st_ready", 64'(st_ready), 64'd0);
        mq.delete();
        sb_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        reset = 1'b1;
        store(32'h500, 32'h5A, 1'b0);
        idle(1'b0);
        idle(1'b1);

        // randomized traffic over a small address set so forwarding hits
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 32'h400 + 32'(4 * $urandom_range(0, 5)), $urandom,
                 1'($urandom), 32'h400 + 32'(4 * $urandom_range(0, 5)),
                 ($urandom % 3) != 0, 1'b0);
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        idle(1'b0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
